// File: rtl/note_scroller.sv
// note_scroller
// Feeds the 4x4 square drawer for one horizontal drum lane. Each slot holds a
// note (valid, x, colour). On every frame tick the slots are walked in order;
// each active note is erased at its old x, moved left by STEP and redrawn.
// Notes that would move past x=0 are dropped and reported as misses.
//
// Ports
//   clk, resetn     system clock, synchronous active-low reset
//   frame_tick      one-cycle pulse, start of frame (queued one deep)
//   spawn           one-cycle pulse, request a new note of colour spawn_colour
//   sq_req/sq_ack   request/acknowledge handshake to the square drawer
//   sq_x/sq_y       square top-left corner, sq_y is always LANE_Y
//   sq_colour       square colour, 0 erases
//   miss            pulse, a note scrolled off the left edge
//   spawn_drop      pulse, spawn discarded because every slot was full
//   overrun         pulse, frame_tick arrived with a tick already queued
//   busy            high while a pass is in progress
//   active_count    number of valid slots
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | service pending spawn, else start a pass if a tick is queued
// CHECK | look at slot idx, skip it if empty
// ERASE | request colour-0 square at the old x, wait for ack
// MOVE  | step the note left, or drop it as a miss
// DRAW  | request the note colour at the new x, wait for ack
// NEXT  | advance idx or finish the pass

module note_scroller #(
  parameter int         NUM_NOTES = 8,
  parameter logic [6:0] LANE_Y    = 7'd60,
  parameter logic [7:0] SPAWN_X   = 8'd156,
  parameter int         STEP      = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic [2:0] spawn_colour,
  output logic       sq_req,
  input  logic       sq_ack,
  output logic [7:0] sq_x,
  output logic [6:0] sq_y,
  output logic [2:0] sq_colour,
  output logic       miss,
  output logic       spawn_drop,
  output logic       overrun,
  output logic       busy,
  output logic [4:0] active_count
);

  localparam int            IW       = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NOTES - 1);
  localparam logic [7:0]    STEP_X   = 8'(STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_NEXT
  } state_t;

  state_t state, state_d;

  logic [NUM_NOTES-1:0] slot_valid;
  logic [7:0]           slot_x   [NUM_NOTES];
  logic [2:0]           slot_col [NUM_NOTES];

  logic [IW-1:0] idx;
  logic          tick_pending;
  logic          spawn_pending;
  logic [2:0]    spawn_col;

  logic          cur_valid;
  logic [7:0]    cur_x;
  logic [2:0]    cur_col;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic [4:0]    valid_cnt;

  logic start_pass, ins_spawn, ld_erase, ld_draw, req_done;
  logic do_step, do_miss, idx_clr, idx_inc;

  assign sq_y = LANE_Y;
  assign busy = (state != S_IDLE);

  assign cur_valid = slot_valid[idx];
  assign cur_x     = slot_x[idx];
  assign cur_col   = slot_col[idx];

  // Lowest-index free slot: scan downward so the last hit is the lowest.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_NOTES - 1; k >= 0; k--) begin
      if (!slot_valid[k]) begin
        free_found = 1'b1;
        free_idx   = IW'(k);
      end
    end
  end

  always_comb begin
    valid_cnt = '0;
    for (int k = 0; k < NUM_NOTES; k++) begin
      valid_cnt = valid_cnt + {4'd0, slot_valid[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d    = state;
    start_pass = 1'b0;
    ins_spawn  = 1'b0;
    ld_erase   = 1'b0;
    ld_draw    = 1'b0;
    req_done   = 1'b0;
    do_step    = 1'b0;
    do_miss    = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        // A pending spawn is inserted first; the pass waits one cycle.
        if (spawn_pending) begin
          ins_spawn = 1'b1;
        end else if (tick_pending) begin
          start_pass = 1'b1;
          idx_clr    = 1'b1;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cur_valid) begin
          ld_erase = 1'b1;
          state_d  = S_ERASE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_ERASE: begin
        if (sq_ack && sq_req) begin
          req_done = 1'b1;
          state_d  = S_MOVE;
        end
      end
      S_MOVE: begin
        // Unsigned compare first so x never wraps below zero.
        if (cur_x < STEP_X) begin
          do_miss = 1'b1;
          state_d = S_NEXT;
        end else begin
          do_step = 1'b1;
          ld_draw = 1'b1;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (sq_ack && sq_req) begin
          req_done = 1'b1;
          state_d  = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_inc = 1'b1;
          state_d = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_valid    <= '0;
      for (int k = 0; k < NUM_NOTES; k++) begin
        slot_x[k]   <= '0;
        slot_col[k] <= '0;
      end
      idx           <= '0;
      tick_pending  <= 1'b0;
      spawn_pending <= 1'b0;
      spawn_col     <= '0;
      sq_req        <= 1'b0;
      sq_x          <= '0;
      sq_colour     <= '0;
      miss          <= 1'b0;
      spawn_drop    <= 1'b0;
      overrun       <= 1'b0;
      active_count  <= '0;
    end else begin
      miss         <= do_miss;
      spawn_drop   <= ins_spawn && !free_found;
      // A tick landing on the pass-start cycle stays queued, not an overrun.
      overrun      <= frame_tick && tick_pending && !start_pass;
      tick_pending <= frame_tick || (tick_pending && !start_pass);
      active_count <= valid_cnt;

      // A new spawn pulse wins over clearing, so it is never lost.
      if (spawn) begin
        spawn_pending <= 1'b1;
        spawn_col     <= spawn_colour;
      end else if (ins_spawn) begin
        spawn_pending <= 1'b0;
      end

      if (ins_spawn && free_found) begin
        slot_valid[free_idx] <= 1'b1;
        slot_x[free_idx]     <= SPAWN_X;
        slot_col[free_idx]   <= spawn_col;
      end

      if (do_miss) slot_valid[idx] <= 1'b0;
      if (do_step) slot_x[idx]     <= cur_x - STEP_X;

      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;

      // Request fields are loaded on entry to ERASE/DRAW and held until ack.
      if (ld_erase) begin
        sq_req    <= 1'b1;
        sq_x      <= cur_x;
        sq_colour <= 3'b000;
      end else if (ld_draw) begin
        sq_req    <= 1'b1;
        sq_x      <= cur_x - STEP_X;
        sq_colour <= cur_col;
      end else if (req_done) begin
        sq_req    <= 1'b0;
      end
    end
  end

endmodule
